// File: rtl/audio_sample_fifo_if.sv
// Stream bundle between the CPU/DMA producer, the sample FIFO and the DAC consumer.
// Slave is the FIFO's view. Master is the view of the producer and consumer side.
interface audio_sample_fifo_if;
  logic        inport_tvalid_i;
  logic [31:0] inport_tdata_i;
  logic        inport_tready_o;
  logic        outport_tvalid_o;
  logic [31:0] outport_tdata_o;
  logic [3:0]  outport_tstrb_o;
  logic [3:0]  outport_tdest_o;
  logic        outport_tlast_o;
  logic        outport_tready_i;

  modport slave (
    input  inport_tvalid_i, inport_tdata_i, outport_tready_i,
    output inport_tready_o, outport_tvalid_o, outport_tdata_o,
           outport_tstrb_o, outport_tdest_o, outport_tlast_o
  );

  modport master (
    output inport_tvalid_i, inport_tdata_i, outport_tready_i,
    input  inport_tready_o, outport_tvalid_o, outport_tdata_o,
           outport_tstrb_o, outport_tdest_o, outport_tlast_o
  );
endinterface

// File: rtl/audio_sample_fifo.sv
// Show-ahead stereo sample FIFO feeding the sigma-delta DAC.
// It also generates the exact-average sample strobe and counts strobes that find the FIFO empty.
module audio_sample_fifo #(
  parameter int unsigned CLK_RATE_HZ = 50000000,
  parameter int unsigned AUDIO_RATE  = 44100,
  parameter int unsigned ADDR_W      = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              flush_i,
  audio_sample_fifo_if.slave axis,
  output logic              audio_clk_o,
  output logic [ADDR_W:0]   level_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [15:0]       underrun_o
);

  localparam int unsigned       DEPTH      = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   FULL_LEVEL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [32:0]       RATE_INC   = 33'(AUDIO_RATE);
  localparam logic [32:0]       RATE_MOD   = 33'(CLK_RATE_HZ);

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   level;
  logic              push;
  logic              pop;
  logic [31:0]       acc;
  logic [32:0]       acc_sum;
  logic [15:0]       underrun_cnt;

  // Flags come from the registered level, so a pop cannot open a slot for a push in the same cycle.
  assign full_o  = (level == FULL_LEVEL);
  assign empty_o = (level == '0);
  assign level_o = level;

  assign axis.inport_tready_o  = !full_o;
  assign axis.outport_tvalid_o = !empty_o;
  assign axis.outport_tdata_o  = empty_o ? '0 : mem[rd_ptr];
  assign axis.outport_tstrb_o  = 4'hF;
  assign axis.outport_tdest_o  = 4'h0;
  assign axis.outport_tlast_o  = 1'b1;

  // A flush drops any push or pop offered in the same cycle.
  assign push = axis.inport_tvalid_i && !full_o && !flush_i;
  assign pop  = axis.outport_tready_i && !empty_o && !flush_i;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= axis.inport_tdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // The sum is one bit wider so that the compare cannot overflow near 2^32.
  assign acc_sum = {1'b0, acc} + RATE_INC;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc         <= '0;
      audio_clk_o <= 1'b0;
    end else if (!enable_i) begin
      acc         <= '0;
      audio_clk_o <= 1'b0;
    end else if (acc_sum >= RATE_MOD) begin
      acc         <= 32'(acc_sum - RATE_MOD);
      audio_clk_o <= 1'b1;
    end else begin
      acc         <= acc_sum[31:0];
      audio_clk_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      underrun_cnt <= '0;
    end else if (flush_i) begin
      underrun_cnt <= '0;
    end else if (audio_clk_o && empty_o && (underrun_cnt != '1)) begin
      underrun_cnt <= underrun_cnt + 1'b1;
    end
  end

  assign underrun_o = underrun_cnt;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Directed bench for audio_sample_fifo using short rate parameters (1000 Hz clock, 300 Hz strobe).
// It applies a vector table for single-cycle FIFO operations and hand sequences for the multi-cycle corners.
module tb_audio_sample_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        flush;
  logic        audio_clk;
  logic [8:0]  level;
  logic        full;
  logic        empty;
  logic [15:0] underrun;

  int applied    = 0;
  int miscompares = 0;

  audio_sample_fifo_if bus ();

  always #5 clk = ~clk;

  audio_sample_fifo #(
    .CLK_RATE_HZ(1000),
    .AUDIO_RATE (300),
    .ADDR_W     (8)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .enable_i   (enable),
    .flush_i    (flush),
    .axis       (bus),
    .audio_clk_o(audio_clk),
    .level_o    (level),
    .full_o     (full),
    .empty_o    (empty),
    .underrun_o (underrun)
  );

  typedef struct {
    logic        flush;
    logic        push;
    logic [31:0] data;
    logic        pop;
    logic [8:0]  level;
    logic        valid;
    logic [31:0] head;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_level"},    32'(level), 32'd0);
    check({tag, "_full"},     32'(full), 32'd0);
    check({tag, "_empty"},    32'(empty), 32'd1);
    check({tag, "_in_ready"}, 32'(bus.inport_tready_o), 32'd1);
    check({tag, "_valid"},    32'(bus.outport_tvalid_o), 32'd0);
    check({tag, "_tdata"},    bus.outport_tdata_o, 32'd0);
    check({tag, "_underrun"}, 32'(underrun), 32'd0);
    check({tag, "_audio_clk"}, 32'(audio_clk), 32'd0);
  endtask

  task automatic wait_strobe(input string name);
    int n = 0;
    while (!audio_clk && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!audio_clk) begin
      applied++;
      miscompares++;
      $display("FAIL %s: got no strobe, want strobe within 20 cycles", name);
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] d);
    bus.inport_tvalid_i = 1'b1;
    bus.inport_tdata_i  = d;
    @(negedge clk);
    bus.inport_tvalid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int strobe_edges [6] = '{4, 7, 10, 14, 17, 20};
    int idx;
    int cycles;
    logic pend;
    logic exp_clk;
    int exp_ur;
    logic [15:0] sat_exp [3] = '{16'hFFFE, 16'hFFFF, 16'hFFFF};

    rst = 1'b1;
    enable = 1'b0;
    flush = 1'b0;
    bus.inport_tvalid_i  = 1'b0;
    bus.inport_tdata_i   = '0;
    bus.outport_tready_i = 1'b0;

    vecs[0] = '{1'b0, 1'b1, 32'h1111_1111, 1'b0, 9'd1, 1'b1, 32'h1111_1111};
    vecs[1] = '{1'b0, 1'b1, 32'h2222_2222, 1'b0, 9'd2, 1'b1, 32'h1111_1111};
    vecs[2] = '{1'b0, 1'b0, 32'h0,         1'b1, 9'd1, 1'b1, 32'h2222_2222};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_A5A5, 1'b1, 9'd1, 1'b1, 32'h0000_A5A5};
    vecs[4] = '{1'b0, 1'b0, 32'h0,         1'b1, 9'd0, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 32'h0,         1'b1, 9'd0, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 1'b1, 32'h3333_3333, 1'b0, 9'd0, 1'b0, 32'h0};
    vecs[7] = '{1'b0, 1'b1, 32'h4444_4444, 1'b0, 9'd1, 1'b1, 32'h4444_4444};
    vecs[8] = '{1'b1, 1'b0, 32'h0,         1'b0, 9'd0, 1'b0, 32'h0};

    #7;
    check_reset("reset");
    check("tstrb", 32'(bus.outport_tstrb_o), 32'hF);
    check("tdest", 32'(bus.outport_tdest_o), 32'h0);
    check("tlast", 32'(bus.outport_tlast_o), 32'h1);

    // Rate generator from reset release, empty FIFO so every strobe is an underrun.
    @(negedge clk);
    rst = 1'b0;
    enable = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      exp_clk = 1'b0;
      exp_ur = 0;
      foreach (strobe_edges[k]) begin
        if (strobe_edges[k] == n) exp_clk = 1'b1;
        if (strobe_edges[k] < n) exp_ur++;
      end
      check($sformatf("rate_edge%0d", n), 32'(audio_clk), 32'(exp_clk));
      check($sformatf("underrun_edge%0d", n), 32'(underrun), 32'(exp_ur));
      check($sformatf("valid_edge%0d", n), 32'(bus.outport_tvalid_o), 32'd0);
    end

    enable = 1'b0;
    repeat (5) @(negedge clk);
    check("underrun_after_disable", 32'(underrun), 32'd6);
    enable = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      check($sformatf("reenable_edge%0d", n), 32'(audio_clk), 32'(n == 4));
    end
    // Flush lands on the cycle the strobe is high: flush must win over the increment.
    enable = 1'b0;
    pulse_flush();
    check("flush_vs_underrun", 32'(underrun), 32'd0);

    // Vector table of single-cycle FIFO operations, rate generator off.
    for (int i = 0; i < 9; i++) begin
      flush = vecs[i].flush;
      bus.inport_tvalid_i  = vecs[i].push;
      bus.inport_tdata_i   = vecs[i].data;
      bus.outport_tready_i = vecs[i].pop;
      @(negedge clk);
      flush = 1'b0;
      bus.inport_tvalid_i  = 1'b0;
      bus.outport_tready_i = 1'b0;
      check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].level));
      check($sformatf("vec%0d_valid", i), 32'(bus.outport_tvalid_o), 32'(vecs[i].valid));
      check($sformatf("vec%0d_head", i), bus.outport_tdata_o, vecs[i].head);
      check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].level == 9'd0));
    end

    // Flush at level 10 with a concurrent push and a nonzero underrun count.
    enable = 1'b1;
    wait_strobe("underrun_prep");
    @(negedge clk);
    enable = 1'b0;
    check("underrun_prep", 32'(underrun), 32'd1);
    for (int i = 0; i < 10; i++) push_word(32'h100 + 32'(i));
    check("level10", 32'(level), 32'd10);
    check("level10_head", bus.outport_tdata_o, 32'h100);
    flush = 1'b1;
    push_word(32'h0000_0BAD);
    flush = 1'b0;
    check("flush_level", 32'(level), 32'd0);
    check("flush_underrun", 32'(underrun), 32'd0);
    check("flush_valid", 32'(bus.outport_tvalid_o), 32'd0);
    push_word(32'h0000_0077);
    check("post_flush_level", 32'(level), 32'd1);
    check("post_flush_head", bus.outport_tdata_o, 32'h77);
    pulse_flush();

    // Fill to full, then offer one more word that must be held off.
    for (int i = 0; i < 256; i++) push_word(32'(i));
    check("fill_level", 32'(level), 32'd256);
    check("fill_full", 32'(full), 32'd1);
    check("fill_in_ready", 32'(bus.inport_tready_o), 32'd0);
    bus.inport_tvalid_i = 1'b1;
    bus.inport_tdata_i  = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("overfill%0d_level", i), 32'(level), 32'd256);
    end
    bus.inport_tvalid_i = 1'b0;
    check("full_head", bus.outport_tdata_o, 32'h0);

    // DAC consumer: latch on strobe with valid, pulse tready one cycle later.
    enable = 1'b1;
    idx = 0;
    cycles = 0;
    pend = 1'b0;
    while (idx < 256 && cycles < 3000) begin
      @(negedge clk);
      cycles++;
      bus.outport_tready_i = pend;
      pend = 1'b0;
      if (audio_clk && bus.outport_tvalid_o) begin
        check($sformatf("drain%0d", idx), bus.outport_tdata_o, 32'(idx));
        idx++;
        pend = 1'b1;
      end
    end
    if (idx < 256) begin
      applied++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d words, want 256", idx);
    end
    @(negedge clk);
    bus.outport_tready_i = pend;
    @(negedge clk);
    bus.outport_tready_i = 1'b0;
    enable = 1'b0;
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_tdata", bus.outport_tdata_o, 32'h0);
    check("drain_valid", 32'(bus.outport_tvalid_o), 32'd0);

    // Underrun saturation: preload near the top, then let strobes hit the empty FIFO.
    pulse_flush();
    force dut.underrun_cnt = 16'hFFFD;
    @(negedge clk);
    release dut.underrun_cnt;
    @(negedge clk);
    check("sat_preload", 32'(underrun), 32'h0000_FFFD);
    enable = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_strobe($sformatf("sat_strobe%0d", k));
      @(negedge clk);
      check($sformatf("sat%0d", k), 32'(underrun), 32'(sat_exp[k]));
    end
    enable = 1'b0;
    pulse_flush();

    // Asynchronous reset mid-fill, between clock edges.
    for (int i = 0; i < 5; i++) push_word(32'hC0 + 32'(i));
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check("prereset_level", 32'(level), 32'd5);
    #1 rst = 1'b1;
    #1;
    check_reset("async_reset");
    @(negedge clk);
    rst = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      check($sformatf("post_reset_edge%0d", n), 32'(audio_clk), 32'(n == 4));
    end
    enable = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
